// File: rtl/alu_rs.sv
// Reservation station feeding the integer ALU: holds micro-ops until both operands arrive and issues one ready entry per cycle.
// Optional macro ALU_RS_BYPASS_EN lets a fully ready dispatch go straight to the outputs when no stored entry is ready.
module alu_rs #(
  parameter int RS_SIZE = 16,
  parameter int TAG_W = 4,
  parameter int OPENUM_W = 6,
  parameter int DATA_W = 32,
  parameter logic [OPENUM_W-1:0] OPENUM_NOP = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                clear,
  input  logic                in_valid,
  input  logic [OPENUM_W-1:0] in_openum,
  input  logic [DATA_W-1:0]   in_v1,
  input  logic [DATA_W-1:0]   in_v2,
  input  logic                in_q1_busy,
  input  logic                in_q2_busy,
  input  logic [TAG_W-1:0]    in_q1,
  input  logic [TAG_W-1:0]    in_q2,
  input  logic [DATA_W-1:0]   in_imm,
  input  logic [DATA_W-1:0]   in_pc,
  input  logic [TAG_W-1:0]    in_rob_tag,
  output logic                full,
  input  logic                alu_cdb_valid,
  input  logic [TAG_W-1:0]    alu_cdb_tag,
  input  logic [DATA_W-1:0]   alu_cdb_value,
  input  logic                lsb_cdb_valid,
  input  logic [TAG_W-1:0]    lsb_cdb_tag,
  input  logic [DATA_W-1:0]   lsb_cdb_value,
  output logic [OPENUM_W-1:0] out_openum,
  output logic [DATA_W-1:0]   out_v1,
  output logic [DATA_W-1:0]   out_v2,
  output logic [DATA_W-1:0]   out_imm,
  output logic [DATA_W-1:0]   out_pc,
  output logic [TAG_W-1:0]    out_rob_tag
);
  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0]  busy_reg;
  logic [RS_SIZE-1:0]  q1_busy_reg;
  logic [RS_SIZE-1:0]  q2_busy_reg;
  logic [OPENUM_W-1:0] openum_reg  [RS_SIZE];
  logic [DATA_W-1:0]   v1_reg      [RS_SIZE];
  logic [DATA_W-1:0]   v2_reg      [RS_SIZE];
  logic [TAG_W-1:0]    q1_reg      [RS_SIZE];
  logic [TAG_W-1:0]    q2_reg      [RS_SIZE];
  logic [DATA_W-1:0]   imm_reg     [RS_SIZE];
  logic [DATA_W-1:0]   pc_reg      [RS_SIZE];
  logic [TAG_W-1:0]    rob_tag_reg [RS_SIZE];

  logic [RS_SIZE-1:0]  ready;
  logic [RS_SIZE-1:0]  q1_busy_next;
  logic [RS_SIZE-1:0]  q2_busy_next;
  logic [DATA_W-1:0]   v1_next [RS_SIZE];
  logic [DATA_W-1:0]   v2_next [RS_SIZE];

  // Per-entry CDB snoop; ALU bus has priority when both carry the same tag.
  generate
    for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_entry
      logic q1_alu, q1_lsb, q2_alu, q2_lsb;
      assign q1_alu = alu_cdb_valid && q1_busy_reg[gi] && (q1_reg[gi] == alu_cdb_tag);
      assign q1_lsb = lsb_cdb_valid && q1_busy_reg[gi] && (q1_reg[gi] == lsb_cdb_tag);
      assign q2_alu = alu_cdb_valid && q2_busy_reg[gi] && (q2_reg[gi] == alu_cdb_tag);
      assign q2_lsb = lsb_cdb_valid && q2_busy_reg[gi] && (q2_reg[gi] == lsb_cdb_tag);
      assign q1_busy_next[gi] = q1_busy_reg[gi] && !(q1_alu || q1_lsb);
      assign q2_busy_next[gi] = q2_busy_reg[gi] && !(q2_alu || q2_lsb);
      assign v1_next[gi] = q1_alu ? alu_cdb_value : (q1_lsb ? lsb_cdb_value : v1_reg[gi]);
      assign v2_next[gi] = q2_alu ? alu_cdb_value : (q2_lsb ? lsb_cdb_value : v2_reg[gi]);
      assign ready[gi] = busy_reg[gi] && !q1_busy_reg[gi] && !q2_busy_reg[gi];
    end
  endgenerate

  // Same-cycle forwarding for the incoming micro-op.
  logic              d_q1_alu, d_q1_lsb, d_q2_alu, d_q2_lsb;
  logic              d_q1_busy, d_q2_busy;
  logic [DATA_W-1:0] d_v1, d_v2;

  assign d_q1_alu  = alu_cdb_valid && in_q1_busy && (in_q1 == alu_cdb_tag);
  assign d_q1_lsb  = lsb_cdb_valid && in_q1_busy && (in_q1 == lsb_cdb_tag);
  assign d_q2_alu  = alu_cdb_valid && in_q2_busy && (in_q2 == alu_cdb_tag);
  assign d_q2_lsb  = lsb_cdb_valid && in_q2_busy && (in_q2 == lsb_cdb_tag);
  assign d_q1_busy = in_q1_busy && !(d_q1_alu || d_q1_lsb);
  assign d_q2_busy = in_q2_busy && !(d_q2_alu || d_q2_lsb);
  assign d_v1 = d_q1_alu ? alu_cdb_value : (d_q1_lsb ? lsb_cdb_value : in_v1);
  assign d_v2 = d_q2_alu ? alu_cdb_value : (d_q2_lsb ? lsb_cdb_value : in_v2);

  logic             issue_found, free_found;
  logic [IDX_W-1:0] issue_idx, free_idx;

  always_comb begin
    issue_found = 1'b0;
    issue_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        issue_found = 1'b1;
        issue_idx   = IDX_W'(i);
      end
      if (!busy_reg[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // No free entry is exactly "all entries busy"; a same-cycle issue is not anticipated.
  assign full = !free_found;

  logic bypass;
`ifdef ALU_RS_BYPASS_EN
  assign bypass = in_valid && !d_q1_busy && !d_q2_busy && !issue_found;
`else
  assign bypass = 1'b0;
`endif

  logic do_dispatch;
  assign do_dispatch = in_valid && free_found && !bypass;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      busy_reg    <= '0;
      out_openum  <= OPENUM_NOP;
      out_v1      <= '0;
      out_v2      <= '0;
      out_imm     <= '0;
      out_pc      <= '0;
      out_rob_tag <= '0;
    end else if (rdy) begin
      q1_busy_reg <= q1_busy_next;
      q2_busy_reg <= q2_busy_next;
      for (int i = 0; i < RS_SIZE; i++) begin
        v1_reg[i] <= v1_next[i];
        v2_reg[i] <= v2_next[i];
      end

      if (issue_found) begin
        busy_reg[issue_idx] <= 1'b0;
        out_openum  <= openum_reg[issue_idx];
        out_v1      <= v1_reg[issue_idx];
        out_v2      <= v2_reg[issue_idx];
        out_imm     <= imm_reg[issue_idx];
        out_pc      <= pc_reg[issue_idx];
        out_rob_tag <= rob_tag_reg[issue_idx];
      end else if (bypass) begin
        out_openum  <= in_openum;
        out_v1      <= d_v1;
        out_v2      <= d_v2;
        out_imm     <= in_imm;
        out_pc      <= in_pc;
        out_rob_tag <= in_rob_tag;
      end else begin
        out_openum <= OPENUM_NOP;
      end

      // Written last so the new entry overrides the snoop update of its free slot.
      if (do_dispatch) begin
        busy_reg[free_idx]    <= 1'b1;
        openum_reg[free_idx]  <= in_openum;
        v1_reg[free_idx]      <= d_v1;
        v2_reg[free_idx]      <= d_v2;
        q1_busy_reg[free_idx] <= d_q1_busy;
        q2_busy_reg[free_idx] <= d_q2_busy;
        q1_reg[free_idx]      <= in_q1;
        q2_reg[free_idx]      <= in_q2;
        imm_reg[free_idx]     <= in_imm;
        pc_reg[free_idx]      <= in_pc;
        rob_tag_reg[free_idx] <= in_rob_tag;
      end
    end
  end
endmodule
